// File: rtl/arith_rsh_if.sv
// Operand/result bundle for the registered arithmetic right shifter.
// Producer drives p/i/in_valid; the shifter returns o/out_valid.
interface arith_rsh_if #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] p;
  logic [SHW-1:0]   i;
  logic [WIDTH-1:0] o;
  logic             out_valid;

  modport master (
    output in_valid, p, i,
    input  o, out_valid
  );

  modport slave (
    input  in_valid, p, i,
    output o, out_valid
  );
endinterface

// File: rtl/arith_rsh.sv
// Registered arithmetic right shift o = p >>> i built as a log2 barrel shifter.
// One-cycle latency, one result per cycle, no backpressure.
module arith_rsh #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input logic         clk,
  input logic         rst,
  arith_rsh_if.slave  bus
);

  logic signed [WIDTH-1:0] st [SHW+1];
  logic [WIDTH-1:0]        o_d, o_q;
  logic                    vld_d, vld_q;

  assign st[0] = bus.p;

  // Stage k shifts by 2^k; >>> on a signed value sign-fills,
  // including shifts at or beyond WIDTH.
  for (genvar k = 0; k < SHW; k++) begin : g_stage
    localparam int SH = 2 ** k;
    assign st[k+1] = bus.i[k] ? (st[k] >>> SH) : st[k];
  end

  always_comb begin
    o_d   = o_q;
    vld_d = 1'b0;
    if (bus.in_valid) begin
      o_d   = st[SHW];
      vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      o_q   <= o_d;
      vld_q <= vld_d;
    end
  end

  assign bus.o         = o_q;
  assign bus.out_valid = vld_q;

endmodule

// File: tb/tb_arith_rsh.sv
// Random and directed checks of arith_rsh against a floor(p/2^i) model.
// Model state tracks the expected o/out_valid after every clock edge.
module tb_arith_rsh;
  localparam int W   = 16;
  localparam int SHW = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  logic [W-1:0] exp_o;
  logic         exp_v;

  arith_rsh_if #(.WIDTH(W), .SHW(SHW)) bus ();

  arith_rsh #(.WIDTH(W), .SHW(SHW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // floor(p / 2^sh) with p read as two's complement
  function automatic logic [W-1:0] ref_rsh(
    input logic [W-1:0] pv,
    input int           sh
  );
    longint v, d, q;
    v = longint'($signed(pv));
    d = longint'(1) << sh;
    q = v / d;
    if (v < 0 && (v % d) != 0) q = q - 1;
    return q[W-1:0];
  endfunction

  // Apply one edge; junk on p/i before settling shows only edge values count.
  task automatic step(
    input logic         r,
    input logic         iv,
    input logic [W-1:0] pv,
    input logic [SHW-1:0] iv_sh,
    input string        tag
  );
    rst          = r;
    bus.in_valid = iv;
    bus.p        = W'($urandom);
    bus.i        = SHW'($urandom);
    #2;
    bus.p = pv;
    bus.i = iv_sh;
    @(posedge clk);
    #1;
    if (r) begin
      exp_o = '0;
      exp_v = 1'b0;
    end else begin
      exp_v = iv;
      if (iv) exp_o = ref_rsh(pv, int'(iv_sh));
    end
    check({tag, ".o"}, 32'(bus.o), 32'(exp_o));
    check({tag, ".v"}, 32'(bus.out_valid), 32'(exp_v));
  endtask

  initial begin
    logic [W-1:0] pr;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.p        = '0;
    bus.i        = '0;
    exp_o        = '0;
    exp_v        = 1'b0;

    step(1, 0, 16'h1234, 4'd3, "rst0");
    step(1, 1, 16'h5678, 4'd1, "rst1");
    step(0, 1, 16'h0000, 4'd0, "zero");
    check("zero.lit", 32'(bus.o), 32'h0000);
    step(0, 1, 16'hFFFB, 4'd2, "m5");
    check("m5.lit", 32'(bus.o), 32'hFFFE);
    step(0, 1, 16'h0014, 4'd3, "p20");
    check("p20.lit", 32'(bus.o), 32'h0002);
    step(0, 1, 16'hFFEC, 4'd2, "m20");
    check("m20.lit", 32'(bus.o), 32'hFFFB);
    step(0, 1, 16'h8000, 4'd0, "mn0");
    check("mn0.lit", 32'(bus.o), 32'h8000);
    step(0, 1, 16'h8000, 4'd1, "mn1");
    check("mn1.lit", 32'(bus.o), 32'hC000);
    step(0, 1, 16'h8000, 4'd15, "mn15");
    check("mn15.lit", 32'(bus.o), 32'hFFFF);
    step(0, 1, 16'h7FFF, 4'd15, "mx15");
    check("mx15.lit", 32'(bus.o), 32'h0000);

    step(0, 1, 16'hA5A5, 4'd4, "hold0");
    for (int k = 0; k < 3; k++) begin
      step(0, 0, W'($urandom), SHW'($urandom), "hold");
      check("hold.lit", 32'(bus.o), 32'hFA5A);
    end

    step(1, 1, 16'h1234, 4'd2, "rstv");
    step(0, 1, 16'h4321, 4'd1, "pre");
    step(1, 1, 16'hFFFF, 4'd0, "mid");
    step(0, 1, 16'hF000, 4'd4, "post");
    check("post.lit", 32'(bus.o), 32'hFF00);

    for (int s = 0; s < (1 << SHW); s++) begin
      step(0, 1, 16'h8000, SHW'(s), "bmin");
      step(0, 1, 16'h7FFF, SHW'(s), "bmax");
      step(0, 1, 16'hFFFF, SHW'(s), "bm1");
      step(0, 1, 16'h0001, SHW'(s), "bp1");
    end

    for (int n = 0; n < 200; n++) begin
      for (int s = 0; s < (1 << SHW); s++) begin
        pr = W'($urandom);
        step(0, 1, pr, SHW'(s), "rnd");
      end
    end

    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 19) == 0), 1'($urandom),
           W'($urandom), SHW'($urandom), "mix");
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
